stage_4_mem: RTL and testbench

- Memory-access stage (pipeline stage 4) of the 5-stage in-order core; sits between the execute stage and the write-back stage.
- Registers the execute-stage bundle and captures the synchronous data-SRAM read response, holding it across downstream stalls.
- Performs load byte/halfword selection and sign/zero extension, then selects the final result (load data or ALU result).
- Drives the write-back bundle and a forwarding bus back to the decode stage.

---
 rtl/stage_4_mem.sv | 127 ++++++++++++
 tb/tb_stage_4_mem.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_4_mem.sv
`default_nettype none
// ============================================================================
// Module      : stage_4_mem
// Description : Memory-access stage (stage 4) of the 5-stage in-order core.
//               Registers the execute-stage bundle and captures the synchronous
//               data-SRAM read response, keeping it valid across write-back
//               stalls. Performs load byte/halfword selection with sign or
//               zero extension, then picks load data or the ALU result.
//               Drives the write-back bundle and a decode-stage bypass bus.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               valid_3, allow_4     - execute -> mem handshake
//               stage_3_to_4 [73:0]  - {rf_we, dest, res_from_mem, load_type,
//                                       alu_result, pc}
//               data_sram_rdata      - SRAM read data (valid in first cycle)
//               valid_4, allow_5     - mem -> write-back handshake
//               stage_4_to_5 [69:0]  - {rf_we, dest, final_result, pc}
//               fwd_4 [37:0]         - {fwd_we, fwd_dest, fwd_data}
// Revision    : 1.0 - initial release
// ============================================================================
module stage_4_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_3,
    output logic        allow_4,
    input  logic [73:0] stage_3_to_4,
    input  logic [31:0] data_sram_rdata,
    output logic        valid_4,
    input  logic        allow_5,
    output logic [69:0] stage_4_to_5,
    output logic [37:0] fwd_4
);

    localparam logic [2:0] C_LD_W  = 3'b000;
    localparam logic [2:0] C_LD_B  = 3'b001;
    localparam logic [2:0] C_LD_H  = 3'b010;
    localparam logic [2:0] C_LD_BU = 3'b011;
    localparam logic [2:0] C_LD_HU = 3'b100;

    logic        valid_r;
    logic        first_r;
    logic [73:0] bus_r;
    logic [31:0] rdata_hold;

    // Bundle fields of the registered instruction
    logic        rf_we;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic [2:0]  load_type;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        accept;
    logic [1:0]  off;
    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] extracted;
    logic [31:0] final_result;
    logic        fwd_we;

    assign {rf_we, dest, res_from_mem, load_type, alu_result, pc} = bus_r;

    // No multi-cycle work here, so ready_go is constantly 1.
    assign allow_4 = !valid_r || allow_5;
    assign valid_4 = valid_r;
    assign accept  = valid_3 && allow_4;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r    <= 1'b0;
            first_r    <= 1'b0;
            bus_r      <= '0;
            rdata_hold <= '0;
        end else begin
            if (allow_4) begin
                valid_r <= valid_3;
            end
            if (accept) begin
                bus_r <= stage_3_to_4;
            end
            // first_r marks the single cycle in which the SRAM response for
            // the resident instruction is on data_sram_rdata.
            first_r <= accept;
            if (first_r) begin
                rdata_hold <= data_sram_rdata;
            end
        end
    end

    // Live SRAM data in the first cycle, the captured copy afterwards, so a
    // stalled load keeps presenting the correct value.
    assign load_word = first_r ? data_sram_rdata : rdata_hold;
    assign off       = alu_result[1:0];

    always_comb begin
        load_byte = load_word[7:0];
        case (off)
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            2'd3:    load_byte = load_word[31:24];
            default: load_byte = load_word[7:0];
        endcase
    end

    // off[0] is ignored: misaligned halfwords are not detected in this stage.
    assign load_half = off[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        extracted = load_word;
        case (load_type)
            C_LD_W:  extracted = load_word;
            C_LD_B:  extracted = {{24{load_byte[7]}}, load_byte};
            C_LD_BU: extracted = {24'd0, load_byte};
            C_LD_H:  extracted = {{16{load_half[15]}}, load_half};
            C_LD_HU: extracted = {16'd0, load_half};
            default: extracted = load_word;
        endcase
    end

    assign final_result = res_from_mem ? extracted : alu_result;
    assign fwd_we       = valid_r && rf_we && (dest != 5'd0);

    assign stage_4_to_5 = {valid_r && rf_we, dest, final_result, pc};
    assign fwd_4        = {fwd_we, dest, final_result};

endmodule
`default_nettype wire

// File: tb/tb_stage_4_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_4_mem
// Description : Self-checking bench for stage_4_mem. A transaction-level model
//               of the resident instruction is compared with the DUT outputs
//               on every falling edge; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_4_mem;

    logic        clk;
    logic        reset;
    logic        valid_3;
    logic        allow_4;
    logic [73:0] stage_3_to_4;
    logic [31:0] data_sram_rdata;
    logic        valid_4;
    logic        allow_5;
    logic [69:0] stage_4_to_5;
    logic [37:0] fwd_4;

    int n_cmp  = 0;
    int n_fail = 0;

    stage_4_mem dut (
        .clk             (clk),
        .reset           (reset),
        .valid_3         (valid_3),
        .allow_4         (allow_4),
        .stage_3_to_4    (stage_3_to_4),
        .data_sram_rdata (data_sram_rdata),
        .valid_4         (valid_4),
        .allow_5         (allow_5),
        .stage_4_to_5    (stage_4_to_5),
        .fwd_4           (fwd_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [73:0] mk(input logic we, input logic [4:0] d, input logic rfm,
                                       input logic [2:0] lt, input logic [31:0] alu,
                                       input logic [31:0] pc);
        return {we, d, rfm, lt, alu, pc};
    endfunction

    // Load result computed arithmetically from the instruction rules
    function automatic logic [31:0] load_value(input logic [2:0] lt, input logic [31:0] addr,
                                               input logic [31:0] w);
        int unsigned sh;
        logic [31:0] b, h;
        sh = 8 * int'(addr % 4);
        b  = (w >> sh) & 32'hFF;
        h  = (addr % 4 >= 2) ? (w >> 16) : (w & 32'hFFFF);
        case (lt)
            3'd1:    return (b >= 32'h80)   ? b - 32'h100   : b;
            3'd3:    return b;
            3'd2:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // One held instruction plus the memory word belonging to it.
    logic        m_known = 1'b0;
    logic        m_full;
    logic        m_fresh;
    logic [73:0] m_instr;
    logic [31:0] m_word;

    always @(negedge clk) begin
        logic [31:0] word, res;
        logic        can_take;
        if (m_known) begin
            word = m_fresh ? data_sram_rdata : m_word;
            res  = m_instr[67] ? load_value(m_instr[66:64], m_instr[63:32], word)
                               : m_instr[63:32];
            check("mdl_valid_4", {73'd0, valid_4}, {73'd0, m_full});
            check("mdl_allow_4", {73'd0, allow_4}, {73'd0, !m_full || allow_5});
            check("mdl_stage_4_to_5", {4'd0, stage_4_to_5},
                  {4'd0, m_full && m_instr[73], m_instr[72:68], res, m_instr[31:0]});
            check("mdl_fwd_4", {36'd0, fwd_4},
                  {36'd0, m_full && m_instr[73] && (m_instr[72:68] != 5'd0), m_instr[72:68], res});
            m_word = word;
        end
        // State after the coming rising edge
        if (reset) begin
            m_known = 1'b1;
            m_full  = 1'b0;
            m_fresh = 1'b0;
            m_instr = '0;
            m_word  = '0;
        end else if (m_known) begin
            can_take = !m_full || allow_5;
            m_fresh  = can_take && valid_3;
            if (can_take) begin
                m_full = valid_3;
                if (valid_3) m_instr = stage_3_to_4;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction with allow_5=1, present its SRAM word, check result.
    task automatic load_check(input string name, input logic [73:0] b, input logic [31:0] rd,
                              input logic [31:0] exp);
        valid_3      = 1'b1;
        stage_3_to_4 = b;
        allow_5      = 1'b1;
        tick();
        valid_3         = 1'b0;
        data_sram_rdata = rd;
        #1;
        check(name, {42'd0, stage_4_to_5[63:32]}, {42'd0, exp});
    endtask

    initial begin
        reset           = 1'b1;
        valid_3         = 1'b0;
        stage_3_to_4    = '0;
        data_sram_rdata = '0;
        allow_5         = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        #1;
        check("idle_valid_4", {73'd0, valid_4}, 74'd0);
        check("idle_allow_4", {73'd0, allow_4}, 74'd1);
        check("idle_fwd_4", {36'd0, fwd_4}, 74'd0);
        check("idle_s45", {4'd0, stage_4_to_5}, 74'd0);

        // ALU instruction
        valid_3      = 1'b1;
        stage_3_to_4 = mk(1'b1, 5'd5, 1'b0, 3'd0, 32'h1234_5678, 32'h1C00_0010);
        tick();
        valid_3 = 1'b0;
        #1;
        check("alu_valid_4", {73'd0, valid_4}, 74'd1);
        check("alu_result", {42'd0, stage_4_to_5[63:32]}, 74'h1234_5678);
        check("alu_fwd_4", {36'd0, fwd_4}, {36'd0, 1'b1, 5'd5, 32'h1234_5678});
        check("alu_s45", {4'd0, stage_4_to_5}, {4'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0010});

        // Loads with off=2
        load_check("ld_b",  mk(1'b1, 5'd7, 1'b1, 3'd1, 32'h1000_0002, 32'h1C00_0020),
                   32'h0080_FF11, 32'hFFFF_FF80);
        load_check("ld_bu", mk(1'b1, 5'd7, 1'b1, 3'd3, 32'h1000_0002, 32'h1C00_0024),
                   32'h0080_FF11, 32'h0000_0080);
        load_check("ld_h",  mk(1'b1, 5'd8, 1'b1, 3'd2, 32'h1000_0002, 32'h1C00_0028),
                   32'h8001_0000, 32'hFFFF_8001);
        load_check("ld_hu", mk(1'b1, 5'd8, 1'b1, 3'd4, 32'h1000_0002, 32'h1C00_002C),
                   32'h8001_0000, 32'h0000_8001);

        // LD_W stalled by write-back; a waiting instruction must not enter
        valid_3      = 1'b1;
        stage_3_to_4 = mk(1'b1, 5'd9, 1'b1, 3'd0, 32'h1000_0000, 32'h1C00_0030);
        tick();
        stage_3_to_4    = mk(1'b1, 5'd10, 1'b0, 3'd0, 32'hCAFE_0001, 32'h1C00_0034);
        allow_5         = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        check("ldw_first", {42'd0, stage_4_to_5[63:32]}, 74'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            data_sram_rdata = 32'h0;
            #1;
            check("ldw_stall_result", {42'd0, stage_4_to_5[63:32]}, 74'hDEAD_BEEF);
            check("ldw_stall_allow_4", {73'd0, allow_4}, 74'd0);
            check("ldw_stall_valid_4", {73'd0, valid_4}, 74'd1);
        end
        allow_5 = 1'b1;
        tick();
        valid_3 = 1'b0;
        #1;
        check("release_next_result", {42'd0, stage_4_to_5[63:32]}, 74'hCAFE_0001);
        check("release_next_dest", {69'd0, stage_4_to_5[68:64]}, 74'd10);

        // Back-to-back dest=0, then a bubble, then another instruction
        valid_3      = 1'b1;
        stage_3_to_4 = mk(1'b1, 5'd0, 1'b0, 3'd0, 32'h0000_0011, 32'h1C00_0040);
        tick();
        stage_3_to_4 = mk(1'b1, 5'd0, 1'b0, 3'd0, 32'h0000_0022, 32'h1C00_0044);
        #1;
        check("dest0_a_fwd_we", {73'd0, fwd_4[37]}, 74'd0);
        tick();
        valid_3 = 1'b0;
        #1;
        check("dest0_b_fwd_we", {73'd0, fwd_4[37]}, 74'd0);
        check("dest0_b_valid_4", {73'd0, valid_4}, 74'd1);
        tick();
        valid_3      = 1'b1;
        stage_3_to_4 = mk(1'b1, 5'd3, 1'b0, 3'd0, 32'h0000_0033, 32'h1C00_0048);
        #1;
        check("bubble_valid_4", {73'd0, valid_4}, 74'd0);
        tick();
        valid_3 = 1'b0;
        #1;
        check("after_bubble_valid_4", {73'd0, valid_4}, 74'd1);

        // Sweep every load_type and offset with a mixed write-back pattern
        for (int t = 0; t < 8; t++) begin
            for (int o = 0; o < 4; o++) begin
                valid_3      = 1'b1;
                stage_3_to_4 = mk(1'b1, 5'(t * 4 + o), 1'b1, 3'(t), 32'h2000_0000 + 32'(o),
                                  32'h1C00_1000 + 32'(4 * (t * 4 + o)));
                allow_5      = ((t + o) % 3) != 0;
                tick();
                data_sram_rdata = 32'h8C7B_F00D ^ (32'(t) << 8) ^ 32'(o);
                allow_5         = 1'b1;
                valid_3         = ((t * 4 + o) % 5) == 0;
                tick();
                data_sram_rdata = 32'h5555_AAAA;
            end
        end
        valid_3 = 1'b0;
        tick();

        // Reset during a stalled load
        valid_3      = 1'b1;
        stage_3_to_4 = mk(1'b1, 5'd12, 1'b1, 3'd0, 32'h3000_0000, 32'h1C00_0050);
        tick();
        valid_3         = 1'b0;
        allow_5         = 1'b0;
        data_sram_rdata = 32'h7777_1234;
        tick();
        data_sram_rdata = 32'h0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_valid_4", {73'd0, valid_4}, 74'd0);
        check("rst_allow_4", {73'd0, allow_4}, 74'd1);
        check("rst_s45", {4'd0, stage_4_to_5}, 74'd0);
        check("rst_fwd_4", {36'd0, fwd_4}, 74'd0);
        allow_5 = 1'b1;
        repeat (3) begin
            tick();
            #1;
            check("rst_no_replay", {73'd0, valid_4}, 74'd0);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
